// File: rtl/input_mems_pp.sv
// Ping-pong convolution input memory: one AXIS stream fills the write bank while the
// compute engine reads a completed X/W/K/B set from the read bank.
module input_mems_pp #(
    parameter int INW  = 10,
    parameter int R    = 15,
    parameter int C    = 13,
    parameter int MAXK = 7,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int X_ADDR_BITS = $clog2(R * C),
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic        [INW-1:0]         AXIS_TDATA,
    input  logic                          AXIS_TVALID,
    input  logic        [K_BITS:0]        AXIS_TUSER,
    output logic                          AXIS_TREADY,
    output logic                          inputs_loaded,
    input  logic                          compute_finished,
    output logic        [K_BITS-1:0]      K,
    output logic signed [INW-1:0]         B,
    input  logic        [X_ADDR_BITS-1:0] X_read_addr,
    output logic signed [INW-1:0]         X_data,
    input  logic        [W_ADDR_BITS-1:0] W_read_addr,
    output logic signed [INW-1:0]         W_data,
    output logic                          proto_err
);

    localparam int CNT_BITS = (X_ADDR_BITS > W_ADDR_BITS) ? X_ADDR_BITS : W_ADDR_BITS;
    localparam logic [CNT_BITS-1:0] X_LAST = CNT_BITS'(R * C - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INPUT_W = 2'd1,
        INPUT_B = 2'd2,
        INPUT_X = 2'd3
    } state_t;

    state_t                state_r;
    logic [1:0]            cnt_r;
    logic                  wr_bank_r, rd_bank_r, last_w_r, w_valid_r, tw_r;
    logic [1:0]            wsel_r;
    logic [K_BITS-1:0]     kreg_r [2];
    logic signed [INW-1:0] breg_r [2];
    logic [CNT_BITS-1:0]   counter_r, kk_last_r;
    logic                  tready_r, loaded_r, proto_err_r;
    logic [K_BITS-1:0]     k_r;
    logic signed [INW-1:0] b_r, x_data_r, w_data_r;

    logic signed [INW-1:0] xb_r [2][R*C];
    logic signed [INW-1:0] wb_r [2][MAXK*MAXK];

    logic              hs_s, new_w_s, k_ok_s, idle_hs_s, accept_w_s, accept_x_s, reject_s;
    logic              tw_sel_s, done_s, rel_s, rd_n_s;
    logic [K_BITS-1:0] k_in_s;
    logic [1:0]        cnt_n_s;

    assign AXIS_TREADY   = tready_r & ~reset;
    assign inputs_loaded = loaded_r;
    assign proto_err     = proto_err_r;
    assign K             = k_r;
    assign B             = b_r;
    assign X_data        = x_data_r;
    assign W_data        = w_data_r;

    // Handshake decode, first-word classification and set-count bookkeeping
    always_comb begin
        hs_s       = AXIS_TVALID & AXIS_TREADY;
        new_w_s    = AXIS_TUSER[0];
        k_in_s     = AXIS_TUSER[K_BITS:1];
        k_ok_s     = ({1'b0, k_in_s} >= (K_BITS+1)'(2)) && ({1'b0, k_in_s} <= (K_BITS+1)'(MAXK));
        idle_hs_s  = hs_s && (state_r == IDLE);
        accept_w_s = idle_hs_s && new_w_s && k_ok_s;
        accept_x_s = idle_hs_s && !new_w_s && w_valid_r;
        reject_s   = idle_hs_s && !accept_w_s && !accept_x_s;
        // New weights must never land in the bank the held set is still reading
        if (cnt_r == 2'd1) begin
            tw_sel_s = ~wsel_r[rd_bank_r];
        end else begin
            tw_sel_s = ~last_w_r;
        end
        done_s = hs_s && (state_r == INPUT_X) && (counter_r == X_LAST);
        rel_s  = compute_finished && (cnt_r != 2'd0);
        if (done_s && !rel_s) begin
            cnt_n_s = cnt_r + 2'd1;
        end else if (rel_s && !done_s) begin
            cnt_n_s = cnt_r - 2'd1;
        end else begin
            cnt_n_s = cnt_r;
        end
        rd_n_s = rel_s ? ~rd_bank_r : rd_bank_r;
    end

    // Load FSM, bank pointers and per-bank weight metadata
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 2'd0;
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b0;
            last_w_r    <= 1'b1;
            w_valid_r   <= 1'b0;
            tw_r        <= 1'b0;
            wsel_r      <= 2'b00;
            kreg_r[0]   <= {K_BITS{1'b0}};
            kreg_r[1]   <= {K_BITS{1'b0}};
            breg_r[0]   <= {INW{1'b0}};
            breg_r[1]   <= {INW{1'b0}};
            counter_r   <= {CNT_BITS{1'b0}};
            kk_last_r   <= {CNT_BITS{1'b0}};
            tready_r    <= 1'b1;
            loaded_r    <= 1'b0;
            proto_err_r <= 1'b0;
            k_r         <= {K_BITS{1'b0}};
            b_r         <= {INW{1'b0}};
        end else begin
            cnt_r       <= cnt_n_s;
            rd_bank_r   <= rd_n_s;
            tready_r    <= (cnt_n_s < 2'd2);
            loaded_r    <= (cnt_n_s != 2'd0);
            proto_err_r <= reject_s;
            k_r         <= kreg_r[wsel_r[rd_n_s]];
            b_r         <= breg_r[wsel_r[rd_n_s]];
            if (done_s) begin
                wr_bank_r <= ~wr_bank_r;
            end
            case (state_r)
                IDLE: begin
                    if (accept_w_s) begin
                        tw_r           <= tw_sel_s;
                        kreg_r[tw_sel_s] <= k_in_s;
                        kk_last_r      <= CNT_BITS'(k_in_s) * CNT_BITS'(k_in_s) - CNT_BITS'(1);
                        counter_r      <= CNT_BITS'(1);
                        state_r        <= INPUT_W;
                    end else if (accept_x_s) begin
                        wsel_r[wr_bank_r] <= last_w_r;
                        counter_r         <= CNT_BITS'(1);
                        state_r           <= INPUT_X;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                INPUT_W: begin
                    if (hs_s) begin
                        if (counter_r == kk_last_r) begin
                            state_r <= INPUT_B;
                        end else begin
                            counter_r <= counter_r + CNT_BITS'(1);
                        end
                    end
                end
                INPUT_B: begin
                    if (hs_s) begin
                        breg_r[tw_r]      <= AXIS_TDATA;
                        wsel_r[wr_bank_r] <= tw_r;
                        last_w_r          <= tw_r;
                        w_valid_r         <= 1'b1;
                        counter_r         <= {CNT_BITS{1'b0}};
                        state_r           <= INPUT_X;
                    end
                end
                INPUT_X: begin
                    if (hs_s) begin
                        if (counter_r == X_LAST) begin
                            counter_r <= {CNT_BITS{1'b0}};
                            state_r   <= IDLE;
                        end else begin
                            counter_r <= counter_r + CNT_BITS'(1);
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Bank storage writes; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (hs_s) begin
            case (state_r)
                IDLE: begin
                    if (accept_w_s) begin
                        wb_r[tw_sel_s][W_ADDR_BITS'(0)] <= AXIS_TDATA;
                    end else if (accept_x_s) begin
                        xb_r[wr_bank_r][X_ADDR_BITS'(0)] <= AXIS_TDATA;
                    end
                end
                INPUT_W: wb_r[tw_r][counter_r[W_ADDR_BITS-1:0]] <= AXIS_TDATA;
                INPUT_X: xb_r[wr_bank_r][counter_r[X_ADDR_BITS-1:0]] <= AXIS_TDATA;
                default: ;
            endcase
        end
    end

    // Registered read port; bank select is sampled with the address
    always_ff @(posedge clk) begin
        if (reset) begin
            x_data_r <= {INW{1'b0}};
            w_data_r <= {INW{1'b0}};
        end else begin
            if ({1'b0, X_read_addr} < (X_ADDR_BITS+1)'(R * C)) begin
                x_data_r <= xb_r[rd_bank_r][X_read_addr];
            end else begin
                x_data_r <= {INW{1'b0}};
            end
            if ({1'b0, W_read_addr} < (W_ADDR_BITS+1)'(MAXK * MAXK)) begin
                w_data_r <= wb_r[wsel_r[rd_bank_r]][W_read_addr];
            end else begin
                w_data_r <= {INW{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_input_mems_pp.sv
// Bench for input_mems_pp: a queue-of-sets reference model checks handshakes,
// set accounting, read data, K/B and protocol errors every cycle.
module tb_input_mems_pp;

    localparam int INW = 10, R = 15, C = 13, MAXK = 7;
    localparam int KB = 3, XAB = 8, WAB = 6, NX = R * C;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [INW-1:0] tdata = '0;
    logic           tvalid = 1'b0;
    logic [KB:0]    tuser = '0;
    logic           tready, inputs_loaded, proto_err;
    logic           compute_finished = 1'b0;
    logic [KB-1:0]  k_out;
    logic [INW-1:0] b_out, x_data, w_data;
    logic [XAB-1:0] x_addr = '0;
    logic [WAB-1:0] w_addr = '0;

    always #5 clk = ~clk;

    input_mems_pp dut (
        .clk(clk), .reset(reset),
        .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid), .AXIS_TUSER(tuser), .AXIS_TREADY(tready),
        .inputs_loaded(inputs_loaded), .compute_finished(compute_finished),
        .K(k_out), .B(b_out),
        .X_read_addr(x_addr), .X_data(x_data),
        .W_read_addr(w_addr), .W_data(w_data),
        .proto_err(proto_err)
    );

    int checks = 0, errors = 0;

    // Reference model: complete sets in arrival order, identified by slot
    logic [INW-1:0] mx [4][NX];
    logic [INW-1:0] mw [4][49];
    int             mk [4];
    logic [INW-1:0] mb [4];
    int             q[$];
    int             cur = 0;
    int             pos = 0, nw = 0, pk = 0;
    logic [INW-1:0] pw [49];
    int             lk = 0;
    logic [INW-1:0] lw [49];
    logic [INW-1:0] lb = '0;
    bit             have_w = 1'b0;
    bit             exp_perr = 1'b0;
    bit             bubbles = 1'b0;

    logic [INW-1:0] wq_d[$];
    logic [KB:0]    wq_u[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_word(input logic [INW-1:0] d, input logic [KB:0] u);
        if (pos == 0) begin
            if (u[0] && int'(u[KB:1]) >= 2 && int'(u[KB:1]) <= MAXK) begin
                pk = int'(u[KB:1]);
                nw = pk * pk + 1;
                pw[0] = d;
                pos = 1;
            end else if (!u[0] && have_w) begin
                nw = 0;
                mk[cur] = lk;
                mb[cur] = lb;
                for (int i = 0; i < 49; i++) mw[cur][i] = lw[i];
                mx[cur][0] = d;
                pos = 1;
            end else begin
                exp_perr = 1'b1;
            end
        end else if (pos < nw - 1) begin
            pw[pos] = d;
            pos++;
        end else if (pos == nw - 1) begin
            lk = pk;
            lb = d;
            have_w = 1'b1;
            for (int i = 0; i < 49; i++) begin
                lw[i] = pw[i];
                mw[cur][i] = pw[i];
            end
            mk[cur] = pk;
            mb[cur] = d;
            pos++;
        end else begin
            mx[cur][pos - nw] = d;
            if (pos - nw == NX - 1) begin
                q.push_back(cur);
                cur = (cur + 1) % 4;
                pos = 0;
            end else begin
                pos++;
            end
        end
    endtask

    task automatic prep();
        if (wq_d.size() > 0 && !(bubbles && $urandom_range(0, 3) == 0)) begin
            tvalid = 1'b1;
            tdata  = wq_d[0];
            tuser  = wq_u[0];
        end else begin
            tvalid = 1'b0;
        end
    endtask

    task automatic push_word(input logic [INW-1:0] d, input logic [KB:0] u);
        wq_d.push_back(d);
        wq_u.push_back(u);
    endtask

    task automatic enq_set(input bit nwf, input int k, input int wmode,
                           input logic [INW-1:0] bias, input bit xseq);
        logic [INW-1:0] d;
        if (nwf) begin
            for (int i = 0; i < k * k; i++) begin
                d = (wmode == 0) ? INW'(i + 1) : (wmode == 1) ? INW'(100 + i) : INW'($urandom);
                push_word(d, (i == 0) ? {KB'(k), 1'b1} : (KB+1)'($urandom));
            end
            push_word(bias, (KB+1)'($urandom));
        end
        for (int i = 0; i < NX; i++) begin
            d = xseq ? INW'(i) : INW'($urandom);
            push_word(d, (!nwf && i == 0) ? {KB'($urandom), 1'b0} : (KB+1)'($urandom));
        end
        prep();
    endtask

    // One clock: apply model update for what the DUT saw, then compare everything
    task automatic tick();
        logic           hs, cf;
        logic [INW-1:0] d;
        logic [KB:0]    u;
        int             xa, wa, fp;
        hs = tvalid & tready;
        cf = compute_finished;
        d  = tdata;
        u  = tuser;
        xa = int'(x_addr);
        wa = int'(w_addr);
        fp = (q.size() > 0) ? q[0] : -1;
        @(posedge clk);
        #1;
        compute_finished = 1'b0;
        exp_perr = 1'b0;
        if (cf && q.size() > 0) void'(q.pop_front());
        if (hs) begin
            void'(wq_d.pop_front());
            void'(wq_u.pop_front());
            model_word(d, u);
        end
        check("tready", 32'(tready), 32'(q.size() < 2));
        check("inputs_loaded", 32'(inputs_loaded), 32'(q.size() != 0));
        check("proto_err", 32'(proto_err), 32'(exp_perr));
        if (fp >= 0) begin
            check("x_data", 32'(x_data), 32'(mx[fp][xa]));
            if (wa < mk[fp] * mk[fp]) check("w_data", 32'(w_data), 32'(mw[fp][wa]));
        end
        if (q.size() > 0) begin
            check("k", 32'(k_out), 32'(mk[q[0]]));
            check("b", 32'(b_out), 32'(mb[q[0]]));
            x_addr = XAB'($urandom_range(0, NX - 1));
            w_addr = WAB'($urandom_range(0, mk[q[0]] * mk[q[0]] - 1));
        end
        prep();
    endtask

    task automatic drain(input int bound, input int cfrate);
        int n = 0;
        while (wq_d.size() > 0 && n < bound) begin
            if (cfrate > 0 && $urandom_range(1, cfrate) == 1) compute_finished = 1'b1;
            tick();
            n++;
        end
        check("drain_budget", 32'(wq_d.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tvalid = 1'b0;
        compute_finished = 1'b0;
        wq_d.delete();
        wq_u.delete();
        @(posedge clk);
        #1;
        check("rst_tready", 32'(tready), 32'd0);
        check("rst_loaded", 32'(inputs_loaded), 32'd0);
        check("rst_perr", 32'(proto_err), 32'd0);
        check("rst_k", 32'(k_out), 32'd0);
        check("rst_b", 32'(b_out), 32'd0);
        check("rst_x", 32'(x_data), 32'd0);
        check("rst_w", 32'(w_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        pos = 0;
        have_w = 1'b0;
        exp_perr = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        do_reset();

        // Rejected first words: no weights yet, then K below range
        push_word(INW'($urandom), {3'd3, 1'b0});
        push_word(INW'($urandom), {3'd1, 1'b1});
        push_word(INW'($urandom), {3'd0, 1'b1});
        prep();
        drain(20, 0);
        tick();
        check("reject_loaded", 32'(inputs_loaded), 32'd0);

        // Single set A: K=3, W=1..9, B=-5, X[i]=i
        enq_set(1'b1, 3, 0, 10'h3FB, 1'b1);
        drain(400, 0);
        check("single_loaded", 32'(inputs_loaded), 32'd1);
        check("single_k", 32'(k_out), 32'd3);
        check("single_b", 32'(b_out), 32'h3FB);
        x_addr = XAB'(194);
        w_addr = WAB'(8);
        tick();
        check("single_x194", 32'(x_data), 32'd194);
        check("single_w8", 32'(w_data), 32'd9);

        // Overlap: set B reuses weights while A is held
        enq_set(1'b0, 0, 0, 10'h000, 1'b0);
        drain(400, 0);
        tick();
        tick();
        check("overlap_tready", 32'(tready), 32'd0);
        compute_finished = 1'b1;
        tick();
        check("overlap_loaded", 32'(inputs_loaded), 32'd1);
        check("overlap_k", 32'(k_out), 32'd3);
        x_addr = XAB'(5);
        tick();
        check("overlap_xb", 32'(x_data), 32'(mx[q[0]][5]));

        // New weights K=5 loaded while B still computes
        bubbles = 1'b1;
        enq_set(1'b1, 5, 1, INW'($urandom), 1'b0);
        drain(1000, 0);
        tick();
        tick();
        compute_finished = 1'b1;
        tick();
        check("neww_k", 32'(k_out), 32'd5);
        w_addr = WAB'(24);
        tick();
        check("neww_w24", 32'(w_data), 32'd124);

        // Release coincides with the last X handshake of the next set
        bubbles = 1'b0;
        enq_set(1'b0, 0, 0, 10'h000, 1'b0);
        n = 0;
        while (wq_d.size() > 1 && n < 400) begin
            tick();
            n++;
        end
        compute_finished = 1'b1;
        tick();
        check("simul_loaded", 32'(inputs_loaded), 32'd1);
        check("simul_tready", 32'(tready), 32'd1);
        x_addr = XAB'(7);
        tick();
        check("simul_x", 32'(x_data), 32'(mx[q[0]][7]));

        // Randomized sets with idle bubbles and random releases
        bubbles = 1'b1;
        for (int s = 0; s < 4; s++) begin
            enq_set((s == 0) ? 1'b1 : 1'($urandom_range(0, 1)), int'($urandom_range(2, MAXK)),
                    2, INW'($urandom), 1'b0);
            drain(3000, 30);
        end
        n = 0;
        while (q.size() > 0 && n < 50) begin
            compute_finished = 1'b1;
            tick();
            n++;
        end
        tick();

        // Reset in the middle of an X load
        bubbles = 1'b0;
        enq_set(1'b0, 0, 0, 10'h000, 1'b0);
        n = 0;
        while (wq_d.size() > NX - 50 && n < 200) begin
            tick();
            n++;
        end
        do_reset();
        check("midrst_loaded", 32'(inputs_loaded), 32'd0);
        check("midrst_tready", 32'(tready), 32'd1);
        push_word(INW'($urandom), {3'd3, 1'b0});
        prep();
        tick();
        check("midrst_perr", 32'(proto_err), 32'd1);
        tick();

        // Recovery with a fresh set
        enq_set(1'b1, 4, 2, INW'($urandom), 1'b1);
        drain(400, 0);
        check("recover_loaded", 32'(inputs_loaded), 32'd1);
        check("recover_k", 32'(k_out), 32'd4);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_mems_pp.md
# input_mems_pp

Double-buffered (ping-pong) successor to the single-set convolution input memory. It accepts X, W, K and B over one AXIS stream and stores them in one of two banks while the compute engine reads a previously completed set from the other bank. Loading and computing therefore overlap. Weight sets are held in two physical W banks with per-set bank pointers, so a set may reuse the most recent weights (TUSER[0]=0) or bring new ones without disturbing a set that is still being computed.

## Interface
- INW, 10: data width (signed).
- R, 15: rows of X, R >= 3.
- C, 13: columns of X, C >= 3.
- MAXK, 7: maximum K. Derived: K_BITS = $clog2(MAXK+1), X_ADDR_BITS = $clog2(R*C), W_ADDR_BITS = $clog2(MAXK*MAXK).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- AXIS_TDATA  in  INW  input word.
- AXIS_TVALID  in  1  source valid.
- AXIS_TUSER  in  K_BITS+1  [0]=new_W; [K_BITS:1]=K. Both sampled only on the first word of a set.
- AXIS_TREADY  out  1  sink ready.
- inputs_loaded  out  1  read bank holds a complete set.
- compute_finished  in  1  one-cycle pulse: release the read bank.
- K  out  K_BITS  K of the read bank's weight set.
- B  out  INW signed  bias of the read bank's weight set.
- X_read_addr  in  X_ADDR_BITS; X_data  out  INW signed.
- W_read_addr  in  W_ADDR_BITS; W_data  out  INW signed.
- proto_err  out  1  one-cycle pulse when a first word is rejected.

## Operation
- Storage: XB[0..1] are X banks of R*C words each. WB[0..1] are W banks of MAXK*MAXK words each, with Kreg[0..1] and Breg[0..1] per W bank. Each X bank has wsel[b], the W bank its set uses. Memory contents are not reset.
- Pointers: wr_bank and rd_bank (1 bit each), cnt in 0..2 (complete sets held), last_w (W bank loaded most recently), w_valid (any weights ever loaded).
- Load FSM states:
  - IDLE: waiting for the first word of a set.
  - INPUT_W: loading W words.
  - INPUT_B: loading the bias word.
  - INPUT_X: loading X words.
- AXIS_TREADY = (cnt < 2) in every load state; 0 while reset is asserted. Each handshake (TVALID & TREADY) consumes exactly one word.
- IDLE, first word accepted:
  - new_W=1 and 2 <= K <= MAXK: choose target W bank tw. If cnt==1, tw = the W bank not referenced by wsel[rd_bank]; otherwise tw = last_w ^ 1. Write the word to WB[tw][0] and set Kreg[tw]=K. Go to INPUT_W with counter=1.
  - new_W=0 and w_valid: set wsel[wr_bank]=last_w, write the word to XB[wr_bank][0], go to INPUT_X with counter=1.
  - Otherwise (K out of range, or no weights ever loaded): discard the word, pulse proto_err, stay in IDLE.
- INPUT_W: write WB[tw][counter] row-major. After the word at counter K*K-1, go to INPUT_B.
- INPUT_B: Breg[tw] = word. Set wsel[wr_bank]=tw, last_w=tw, w_valid=1. Go to INPUT_X with counter=0.
- INPUT_X: write XB[wr_bank][counter] row-major. After the word at R*C-1: cnt+1, wr_bank toggles, go to IDLE.
- Reads always come from rd_bank. X_data = XB[rd_bank][X_read_addr] and W_data = WB[wsel[rd_bank]][W_read_addr]. K and B are taken from wsel[rd_bank].
- inputs_loaded = (cnt != 0).
- compute_finished while cnt != 0: cnt-1 and rd_bank toggles. compute_finished while cnt==0 is ignored.
- Simultaneous set completion and compute_finished: cnt is unchanged, both pointers toggle, and inputs_loaded stays 1.

## Timing
- Reset values: AXIS_TREADY=0 during reset, then 1 on the first cycle after reset. inputs_loaded=0, K=0, B=0, X_data=0, W_data=0, proto_err=0. FSM=IDLE, cnt=0, wr_bank=rd_bank=0, last_w=1, w_valid=0.
- A reset asserted mid-load or mid-compute discards all sets and in-progress loads.
- Reads have 1-cycle latency: the address presented in cycle n produces registered data in cycle n+1. The bank select is sampled together with the address.
- After compute_finished in cycle n, addresses presented from cycle n+1 read the new rd_bank. K and B update in cycle n+1.
- inputs_loaded rises in the cycle after the last X handshake, when cnt was 0 beforehand.
- AXIS_TREADY falls in the cycle after the handshake that makes cnt reach 2. It rises in the cycle after compute_finished.
- There is no bubble between sets: a first word may be accepted in the cycle right after the previous set's last X word.
- proto_err asserts in the cycle after the rejected handshake.

## Test plan
- Single set: reset, then load new_W=1, K=3, 9 W words (1..9), B=-5, and 195 X words (X[i]=i). inputs_loaded=1 one cycle after the 205th handshake, K=3, B=-5. Reading X addr 194 and W addr 8 returns 194 and 9 one cycle later.
- Overlap: while set A (K=3) is computing, load set B with new_W=0. All 195 words are accepted, then TREADY=0. Pulse compute_finished: inputs_loaded stays 1, K=3, and X_data now returns B's values.
- New weights during compute: A uses K=3 and W=1..9; load B with new_W=1, K=5, W=100..124. A's W reads still return 1..9. After compute_finished, K=5 and W addr 24 returns 124.
- Rejects: first word after reset with new_W=0 causes one proto_err pulse, the FSM stays IDLE, and no bank fills. new_W=1 with K=1 or K=0 behaves the same. A following valid set still loads correctly.
- Simultaneous events: compute_finished arrives in the same cycle as set B's last X word while cnt==1. Result: cnt stays 1, inputs_loaded stays 1, and reads return B's data.
- Reset mid-load: assert reset after 50 X words, then deassert. inputs_loaded=0, TREADY=1, and a new_W=0 first word is rejected with proto_err.
